// File: rtl/vx_matrix_uop_pkg.sv
// Shared definitions for the matrix micro-op sequencer: kind encoding,
// per-channel FSM states and the micro-op record at the default widths.
package vx_matrix_uop_pkg;

   typedef logic [1:0] uop_kind_t;

   localparam uop_kind_t UOP_NORMAL = 2'b00;
   localparam uop_kind_t UOP_MLOAD  = 2'b01;
   localparam uop_kind_t UOP_MSTORE = 2'b10;
   localparam uop_kind_t UOP_MMUL   = 2'b11;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_EMIT = 1'b1
   } chan_state_e;

   localparam int UOP_NR_BITS   = 6;
   localparam int UOP_XLEN      = 32;
   localparam int UOP_IDX_W     = 3;
   localparam int UOP_PAYLOAD_W = 64;

   typedef struct packed {
      uop_kind_t                  kind;
      logic [UOP_NR_BITS-1:0]     rd;
      logic [UOP_NR_BITS-1:0]     rs1;
      logic [UOP_NR_BITS-1:0]     rs2;
      logic [UOP_XLEN-1:0]        imm;
      logic [UOP_IDX_W-1:0]       idx;
      logic                       last;
      logic [UOP_PAYLOAD_W-1:0]   payload;
   } uop_t;

endpackage

// File: rtl/vx_matrix_uop_chan.sv
// One issue channel: captures a macro, then emits its row-indexed micro-ops
// one per handshake, holding fields stable while the consumer stalls.
module vx_matrix_uop_chan
   import vx_matrix_uop_pkg::*;
#(
   parameter int MAX_ROWS  = 8,
   parameter int NR_BITS   = 6,
   parameter int XLEN      = 32,
   parameter int ROW_BYTES = 4,
   parameter int PAYLOAD_W = 64,
   parameter int IDXW      = $clog2(MAX_ROWS),
   parameter int RW        = IDXW + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 accept,
   input  uop_kind_t            in_kind,
   input  logic [RW-1:0]        in_rows,
   input  logic [NR_BITS-1:0]   in_rd,
   input  logic [NR_BITS-1:0]   in_rs1,
   input  logic [NR_BITS-1:0]   in_rs2,
   input  logic [XLEN-1:0]      in_imm,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 idle,
   output logic                 out_valid,
   input  logic                 out_ready,
   output uop_kind_t            out_kind,
   output logic [NR_BITS-1:0]   out_rd,
   output logic [NR_BITS-1:0]   out_rs1,
   output logic [NR_BITS-1:0]   out_rs2,
   output logic [XLEN-1:0]      out_imm,
   output logic [IDXW-1:0]      out_idx,
   output logic                 out_last,
   output logic [PAYLOAD_W-1:0] out_payload
);

   chan_state_e            state_q, state_d;
   uop_kind_t              kind_q;
   logic [RW-1:0]          n_q, n_in;
   logic [IDXW-1:0]        k_q;
   logic [NR_BITS-1:0]     rd_q, rs1_q, rs2_q;
   logic [XLEN-1:0]        imm_q;
   logic [PAYLOAD_W-1:0]   payload_q;
   logic                   at_last;

   assign idle      = (state_q == CH_IDLE);
   assign out_valid = (state_q == CH_EMIT);
   assign at_last   = ({1'b0, k_q} == (n_q - RW'(1)));
   assign out_last  = out_valid && at_last;

   // Normal instructions and zero-row macros still produce one micro-op.
   always_comb begin
      n_in = in_rows;
      if (in_kind == UOP_NORMAL || in_rows == '0)
         n_in = RW'(1);
      else if (in_rows > RW'(MAX_ROWS))
         n_in = RW'(MAX_ROWS);
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= CH_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CH_IDLE: if (accept) state_d = CH_EMIT;
         CH_EMIT: if (out_ready && at_last) state_d = CH_IDLE;
         default: state_d = CH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kind_q    <= UOP_NORMAL;
         n_q       <= '0;
         k_q       <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         payload_q <= '0;
      end else if (accept && state_q == CH_IDLE) begin
         kind_q    <= in_kind;
         n_q       <= n_in;
         k_q       <= '0;
         rd_q      <= in_rd;
         rs1_q     <= in_rs1;
         rs2_q     <= in_rs2;
         imm_q     <= in_imm;
         payload_q <= in_payload;
      end else if (state_q == CH_EMIT && out_ready && !at_last) begin
         k_q <= k_q + IDXW'(1);
      end
   end

   // Row expansion; register and immediate sums wrap at their field widths.
   always_comb begin
      out_kind    = kind_q;
      out_idx     = k_q;
      out_payload = payload_q;
      out_rd      = rd_q;
      out_rs1     = rs1_q;
      out_rs2     = rs2_q;
      out_imm     = imm_q;
      case (kind_q)
         UOP_MLOAD: begin
            out_rd  = rd_q + NR_BITS'(k_q);
            out_imm = imm_q + XLEN'(k_q) * XLEN'(ROW_BYTES);
         end
         UOP_MSTORE: begin
            out_rs2 = rs2_q + NR_BITS'(k_q);
            out_imm = imm_q + XLEN'(k_q) * XLEN'(ROW_BYTES);
         end
         UOP_MMUL: begin
            out_rd  = rd_q + NR_BITS'(k_q);
            out_rs1 = rs1_q + NR_BITS'(k_q);
            out_rs2 = rs1_q + NR_BITS'(n_q) + NR_BITS'(k_q);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/vx_matrix_uop_seq.sv
// Matrix micro-op sequencer: steers macros to NUM_CH expansion channels.
// Define VX_MATRIX_UOP_PERF_EN to add the perf_uops/perf_clamp counters.
module vx_matrix_uop_seq
   import vx_matrix_uop_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int MAX_ROWS  = 8,
   parameter int NR_BITS   = 6,
   parameter int XLEN      = 32,
   parameter int ROW_BYTES = 4,
   parameter int PAYLOAD_W = 64,
   localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int IDXW     = $clog2(MAX_ROWS),
   localparam int RW       = IDXW + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CHW-1:0]              in_ch,
   input  logic [1:0]                  in_kind,
   input  logic [RW-1:0]               in_rows,
   input  logic [NR_BITS-1:0]          in_rd,
   input  logic [NR_BITS-1:0]          in_rs1,
   input  logic [NR_BITS-1:0]          in_rs2,
   input  logic [XLEN-1:0]             in_imm,
   input  logic [PAYLOAD_W-1:0]        in_payload,
   output logic [NUM_CH-1:0]           out_valid,
   input  logic [NUM_CH-1:0]           out_ready,
   output logic [NUM_CH*2-1:0]         out_kind,
   output logic [NUM_CH*NR_BITS-1:0]   out_rd,
   output logic [NUM_CH*NR_BITS-1:0]   out_rs1,
   output logic [NUM_CH*NR_BITS-1:0]   out_rs2,
   output logic [NUM_CH*XLEN-1:0]      out_imm,
   output logic [NUM_CH*IDXW-1:0]      out_idx,
   output logic [NUM_CH-1:0]           out_last,
   output logic [NUM_CH*PAYLOAD_W-1:0] out_payload
`ifdef VX_MATRIX_UOP_PERF_EN
   ,
   output logic [NUM_CH*32-1:0]        perf_uops,
   output logic [31:0]                 perf_clamp
`endif
);

   logic [NUM_CH-1:0]    chan_idle;
   logic [NUM_CH-1:0]    accept;
   logic [2**CHW-1:0]    idle_ext;

   // Channel numbers beyond NUM_CH read as never ready.
   always_comb begin
      idle_ext = '0;
      for (int i = 0; i < NUM_CH; i++)
         idle_ext[i] = chan_idle[i];
   end

   assign in_ready = idle_ext[in_ch];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
      assign accept[c] = in_valid && in_ready && (in_ch == CHW'(c));

      vx_matrix_uop_chan #(
         .MAX_ROWS  (MAX_ROWS),
         .NR_BITS   (NR_BITS),
         .XLEN      (XLEN),
         .ROW_BYTES (ROW_BYTES),
         .PAYLOAD_W (PAYLOAD_W)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .accept      (accept[c]),
         .in_kind     (in_kind),
         .in_rows     (in_rows),
         .in_rd       (in_rd),
         .in_rs1      (in_rs1),
         .in_rs2      (in_rs2),
         .in_imm      (in_imm),
         .in_payload  (in_payload),
         .idle        (chan_idle[c]),
         .out_valid   (out_valid[c]),
         .out_ready   (out_ready[c]),
         .out_kind    (out_kind[c*2 +: 2]),
         .out_rd      (out_rd[c*NR_BITS +: NR_BITS]),
         .out_rs1     (out_rs1[c*NR_BITS +: NR_BITS]),
         .out_rs2     (out_rs2[c*NR_BITS +: NR_BITS]),
         .out_imm     (out_imm[c*XLEN +: XLEN]),
         .out_idx     (out_idx[c*IDXW +: IDXW]),
         .out_last    (out_last[c]),
         .out_payload (out_payload[c*PAYLOAD_W +: PAYLOAD_W])
      );
   end

`ifdef VX_MATRIX_UOP_PERF_EN
   logic [31:0] uop_cnt [NUM_CH];

   // Both counters saturate instead of wrapping.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (reset)
            uop_cnt[c] <= '0;
         else if (out_valid[c] && out_ready[c] && uop_cnt[c] != '1)
            uop_cnt[c] <= uop_cnt[c] + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         perf_clamp <= '0;
      else if (in_valid && in_ready && in_rows > RW'(MAX_ROWS) && perf_clamp != '1)
         perf_clamp <= perf_clamp + 32'd1;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_perf
      assign perf_uops[c*32 +: 32] = uop_cnt[c];
   end
`endif

endmodule

// File: tb/tb_vx_matrix_uop_seq.sv
// Self-checking bench for vx_matrix_uop_seq: a queue-based expansion model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_vx_matrix_uop_seq;
   import vx_matrix_uop_pkg::*;

   localparam int NUM_CH    = 4;
   localparam int MAX_ROWS  = 8;
   localparam int NR_BITS   = 6;
   localparam int XLEN      = 32;
   localparam int ROW_BYTES = 4;
   localparam int PAYLOAD_W = 64;
   localparam int CHW       = 2;
   localparam int IDXW      = 3;
   localparam int RW        = 4;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        in_valid;
   logic                        in_ready;
   logic [CHW-1:0]              in_ch;
   logic [1:0]                  in_kind;
   logic [RW-1:0]               in_rows;
   logic [NR_BITS-1:0]          in_rd, in_rs1, in_rs2;
   logic [XLEN-1:0]             in_imm;
   logic [PAYLOAD_W-1:0]        in_payload;
   logic [NUM_CH-1:0]           out_valid;
   logic [NUM_CH-1:0]           out_ready;
   logic [NUM_CH*2-1:0]         out_kind;
   logic [NUM_CH*NR_BITS-1:0]   out_rd, out_rs1, out_rs2;
   logic [NUM_CH*XLEN-1:0]      out_imm;
   logic [NUM_CH*IDXW-1:0]      out_idx;
   logic [NUM_CH-1:0]           out_last;
   logic [NUM_CH*PAYLOAD_W-1:0] out_payload;
`ifdef VX_MATRIX_UOP_PERF_EN
   logic [NUM_CH*32-1:0]        perf_uops;
   logic [31:0]                 perf_clamp;
`endif

   int checks   = 0;
   int failures = 0;

   uop_t exp_q  [NUM_CH][$];
   uop_t hs_log [NUM_CH][$];

   always #5 clk = ~clk;

   vx_matrix_uop_seq dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ch       (in_ch),
      .in_kind     (in_kind),
      .in_rows     (in_rows),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_imm      (in_imm),
      .in_payload  (in_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_kind    (out_kind),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_imm     (out_imm),
      .out_idx     (out_idx),
      .out_last    (out_last),
      .out_payload (out_payload)
`ifdef VX_MATRIX_UOP_PERF_EN
      ,
      .perf_uops   (perf_uops),
      .perf_clamp  (perf_clamp)
`endif
   );

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Expected micro-op list for one macro, from the expansion rules.
   function automatic void expandMacro(input int ch, input uop_kind_t kind, input int rows,
                                       input int rd, input int rs1, input int rs2,
                                       input logic [31:0] imm, input logic [63:0] payload);
      int   n;
      uop_t u;
      n = (kind == UOP_NORMAL || rows == 0) ? 1 : ((rows > MAX_ROWS) ? MAX_ROWS : rows);
      for (int k = 0; k < n; k++) begin
         u.kind    = kind;
         u.rd      = 6'(rd);
         u.rs1     = 6'(rs1);
         u.rs2     = 6'(rs2);
         u.imm     = imm;
         u.idx     = 3'(k);
         u.last    = (k == n - 1);
         u.payload = payload;
         if (kind == UOP_MLOAD) begin
            u.rd  = 6'(rd + k);
            u.imm = imm + 32'(k * ROW_BYTES);
         end else if (kind == UOP_MSTORE) begin
            u.rs2 = 6'(rs2 + k);
            u.imm = imm + 32'(k * ROW_BYTES);
         end else if (kind == UOP_MMUL) begin
            u.rd  = 6'(rd + k);
            u.rs1 = 6'(rs1 + k);
            u.rs2 = 6'(rs1 + n + k);
         end
         exp_q[ch].push_back(u);
      end
   endfunction

   function automatic uop_t actUop(input int c);
      uop_t u;
      u.kind    = out_kind[c*2 +: 2];
      u.rd      = out_rd[c*NR_BITS +: NR_BITS];
      u.rs1     = out_rs1[c*NR_BITS +: NR_BITS];
      u.rs2     = out_rs2[c*NR_BITS +: NR_BITS];
      u.imm     = out_imm[c*XLEN +: XLEN];
      u.idx     = out_idx[c*IDXW +: IDXW];
      u.last    = out_last[c];
      u.payload = out_payload[c*PAYLOAD_W +: PAYLOAD_W];
      return u;
   endfunction

   // Compare on the falling edge, then advance the model to what the next
   // rising edge will do with the inputs currently applied.
   always @(negedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         checkOutput("out_valid", out_valid[c], exp_q[c].size() != 0);
         if (exp_q[c].size() != 0 && out_valid[c])
            checkOutput("uop_fields", actUop(c), exp_q[c][0]);
      end
      checkOutput("in_ready", in_ready, exp_q[in_ch].size() == 0);
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (exp_q[c].size() != 0 && out_ready[c]) begin
               if (out_valid[c]) hs_log[c].push_back(actUop(c));
               void'(exp_q[c].pop_front());
            end
         end
         if (in_valid && exp_q[in_ch].size() == 0)
            expandMacro(int'(in_ch), in_kind, int'(in_rows), int'(in_rd), int'(in_rs1),
                        int'(in_rs2), in_imm, in_payload);
      end
   end

   task automatic clearLogs();
      for (int c = 0; c < NUM_CH; c++) hs_log[c].delete();
   endtask

   // Present one macro until accepted; returns just after the accepting edge.
   task automatic applyStimulus(input int ch, input uop_kind_t kind, input int rows,
                                input int rd, input int rs1, input int rs2,
                                input logic [31:0] imm, input logic [63:0] payload);
      int waited = 0;
      in_ch      = CHW'(ch);
      in_kind    = kind;
      in_rows    = RW'(rows);
      in_rd      = NR_BITS'(rd);
      in_rs1     = NR_BITS'(rs1);
      in_rs2     = NR_BITS'(rs2);
      in_imm     = imm;
      in_payload = payload;
      in_valid   = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) checkOutput("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitDrain(input int ch);
      int w = 0;
      do begin
         @(negedge clk);
         #1;
         w++;
      end while ((exp_q[ch].size() != 0 || out_valid[ch]) && w < 100);
      if (exp_q[ch].size() != 0 || out_valid[ch]) checkOutput("drain_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rd_e [4];
      int imm_e [4];
      int rs2_e [3];
      logic [1:0] rstate = 2'b01;

      reset = 1'b1; in_valid = 1'b1; in_ch = '0; in_kind = UOP_MMUL; in_rows = 4'd4;
      in_rd = 6'd5; in_rs1 = 6'd6; in_rs2 = 6'd7; in_imm = 32'h40; in_payload = 64'hFF;
      out_ready = '1;
      repeat (3) @(posedge clk);
      #2;
      for (int c = 0; c < NUM_CH; c++) begin
         in_ch = CHW'(c);
         #1 checkOutput("rst_in_ready", in_ready, 1'b1);
      end
      checkOutput("rst_out_valid", out_valid, '0);
      checkOutput("rst_out_rd", out_rd, '0);
      checkOutput("rst_out_imm", out_imm, '0);
      checkOutput("rst_out_last", out_last, '0);
      checkOutput("rst_out_payload", out_payload[127:0], '0);
      @(posedge clk);
      #1 reset = 1'b0; in_valid = 1'b0; in_ch = '0;

      $display("[TB] MLOAD ch0 rows=4");
      clearLogs();
      applyStimulus(0, UOP_MLOAD, 4, 8, 3, 4, 32'h100, 64'hA0);
      waitDrain(0);
      rd_e  = '{8, 9, 10, 11};
      imm_e = '{32'h100, 32'h104, 32'h108, 32'h10C};
      checkOutput("mload_count", hs_log[0].size(), 4);
      if (hs_log[0].size() == 4)
         for (int i = 0; i < 4; i++) begin
            checkOutput("mload_rd", hs_log[0][i].rd, rd_e[i]);
            checkOutput("mload_imm", hs_log[0][i].imm, imm_e[i]);
            checkOutput("mload_last", hs_log[0][i].last, i == 3);
         end

      $display("[TB] MMUL ch1 rows=2");
      clearLogs();
      applyStimulus(1, UOP_MMUL, 2, 10, 20, 7, 32'h55, 64'hB1);
      waitDrain(1);
      checkOutput("mmul_count", hs_log[1].size(), 2);
      if (hs_log[1].size() == 2) begin
         checkOutput("mmul_u0", {hs_log[1][0].rd, hs_log[1][0].rs1, hs_log[1][0].rs2}, {6'd10, 6'd20, 6'd22});
         checkOutput("mmul_u1", {hs_log[1][1].rd, hs_log[1][1].rs1, hs_log[1][1].rs2}, {6'd11, 6'd21, 6'd23});
      end

      $display("[TB] MSTORE ch2 with stalls, NORMAL ch3 alongside");
      clearLogs();
      applyStimulus(2, UOP_MSTORE, 3, 1, 2, 30, 32'h200, 64'hC2);
      for (int i = 0; i < 5; i++) begin
         out_ready[2] = (i % 2 == 0);
         if (i == 1) begin
            in_ch = 2'd3; in_kind = UOP_NORMAL; in_rows = 4'd5; in_rd = 6'd5;
            in_rs1 = 6'd6; in_rs2 = 6'd7; in_imm = 32'h77; in_payload = 64'hD3;
            in_valid = 1'b1;
         end
         if (i == 2) in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      out_ready[2] = 1'b1;
      waitDrain(2);
      waitDrain(3);
      rs2_e = '{30, 31, 32};
      checkOutput("mstore_count", hs_log[2].size(), 3);
      if (hs_log[2].size() == 3)
         for (int i = 0; i < 3; i++) begin
            checkOutput("mstore_rs2", hs_log[2][i].rs2, rs2_e[i]);
            checkOutput("mstore_imm", hs_log[2][i].imm, 32'h200 + 32'(4 * i));
         end
      checkOutput("normal_count", hs_log[3].size(), 1);
      if (hs_log[3].size() == 1) begin
         checkOutput("normal_rd", hs_log[3][0].rd, 6'd5);
         checkOutput("normal_last", hs_log[3][0].last, 1'b1);
      end

      $display("[TB] MLOAD rows=12 clamps to MAX_ROWS");
      clearLogs();
      applyStimulus(0, UOP_MLOAD, 12, 0, 1, 2, 32'h0, 64'hE0);
      waitDrain(0);
      checkOutput("clamp_count", hs_log[0].size(), 8);
      if (hs_log[0].size() == 8)
         checkOutput("clamp_tail", {hs_log[0][7].idx, hs_log[0][7].last, hs_log[0][7].imm}, {3'd7, 1'b1, 32'h1C});
`ifdef VX_MATRIX_UOP_PERF_EN
      checkOutput("perf_clamp", perf_clamp, 32'd1);
`endif

      $display("[TB] register wrap and zero-row macro");
      clearLogs();
      applyStimulus(0, UOP_MLOAD, 3, 63, 0, 0, 32'h0, 64'hE1);
      applyStimulus(2, UOP_MSTORE, 0, 4, 4, 9, 32'h10, 64'hE2);
      waitDrain(0);
      waitDrain(2);
      checkOutput("wrap_count", hs_log[0].size(), 3);
      if (hs_log[0].size() == 3) checkOutput("wrap_rd", hs_log[0][2].rd, 6'd1);
      checkOutput("zero_rows_count", hs_log[2].size(), 1);

      $display("[TB] reset during MMUL emission");
      clearLogs();
      applyStimulus(1, UOP_MMUL, 4, 1, 2, 3, 32'h0, 64'hF0);
      @(posedge clk);
      #1 reset = rstate[0];
      @(posedge clk);
      #1 reset = rstate[1];
      @(negedge clk);
      #1;
      checkOutput("rstmid_valid", out_valid[1], 1'b0);
      checkOutput("rstmid_rd", out_rd, '0);
      checkOutput("rstmid_hs", hs_log[1].size(), 1);
      @(posedge clk);
      #1;
      clearLogs();
      applyStimulus(1, UOP_NORMAL, 4, 9, 8, 7, 32'h33, 64'hF1);
      waitDrain(1);
      checkOutput("post_rst_count", hs_log[1].size(), 1);
      if (hs_log[1].size() == 1)
         checkOutput("post_rst_uop", {hs_log[1][0].rd, hs_log[1][0].idx, hs_log[1][0].last}, {6'd9, 3'd0, 1'b1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vx_matrix_uop_seq.md
Name: vx_matrix_uop_seq

Overview:
- Parametrised matrix micro-op sequencer. It sits between decode and the per-issue-slot instruction buffers.
- Accepts one decoded macro instruction per cycle and steers it to one of NUM_CH independent channels.
- Each channel expands MLOAD/MSTORE/MMUL macros into a row-indexed stream of scalar micro-ops, one per cycle, under a valid/ready handshake.
- Normal instructions pass through as a single micro-op.

Parameters:
- NUM_CH, 4, number of issue channels (1..8).
- MAX_ROWS, 8, maximum rows per matrix macro (power of 2, 2..16).
- NR_BITS, 6, register index width.
- XLEN, 32, immediate/address width.
- ROW_BYTES, 4, address increment per row for MLOAD/MSTORE.
- PAYLOAD_W, 64, opaque pass-through field width (uuid, wis, tmask, PC, etc.).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  macro instruction valid
- in_ready  out  1  macro accepted when in_valid && in_ready
- in_ch  in  CHW=max(1,clog2(NUM_CH))  target channel
- in_kind  in  2  00 NORMAL, 01 MLOAD, 10 MSTORE, 11 MMUL
- in_rows  in  RW=clog2(MAX_ROWS)+1  row count
- in_rd, in_rs1, in_rs2  in  NR_BITS each  base registers
- in_imm  in  XLEN  base immediate
- in_payload  in  PAYLOAD_W  pass-through
- out_valid  out  NUM_CH  per-channel micro-op valid
- out_ready  in  NUM_CH  per-channel downstream ready
- out_kind  out  NUM_CH*2  kind of parent macro
- out_rd, out_rs1, out_rs2  out  NUM_CH*NR_BITS  expanded registers
- out_imm  out  NUM_CH*XLEN  expanded immediate
- out_idx  out  NUM_CH*(RW-1)  row index k
- out_last  out  NUM_CH  final micro-op of the macro
- out_payload  out  NUM_CH*PAYLOAD_W  pass-through copy

Behaviour:
- Per-channel FSM with states IDLE and EMIT. Channel registers: kind, n, k, rd, rs1, rs2, imm, payload.
- in_ready = (channel in_ch is IDLE). It is combinational on in_ch and independent of in_valid.
- Accept: channel captures the macro and enters EMIT with k=0.
  - n = 1 if kind is NORMAL or in_rows is 0.
  - n = MAX_ROWS if in_rows exceeds MAX_ROWS (clamp).
  - Otherwise n = in_rows.
- Latency: first micro-op has out_valid=1 in the cycle after acceptance.
- out_valid[c] = (state is EMIT). Micro-op k is presented, and fields are held stable, until out_ready[c] is high.
- On a handshake:
  - if k == n-1, go to IDLE (no bubble for the next macro: the channel can accept again in the same cycle in which it reports IDLE);
  - otherwise k increments.
- Expansion rules (k = out_idx; all register arithmetic modulo 2^NR_BITS; imm arithmetic modulo 2^XLEN):
  - NORMAL: fields unchanged.
  - MLOAD: rd+k; rs1 and rs2 unchanged; imm + k*ROW_BYTES.
  - MSTORE: rd unchanged; rs1 unchanged; rs2+k; imm + k*ROW_BYTES.
  - MMUL: rd+k; rs1+k; rs2 = rs1+n+k; imm unchanged.
- out_last = EMIT && (k == n-1).
- Channels are fully independent. A stall on channel c never blocks an accept targeting another channel.
- Reset: all channels go to IDLE with k=0, out_valid=0, and all out_* data outputs are 0. A reset during EMIT discards the remaining micro-ops.
- Register wrap: rd=63, NR_BITS=6, k=2 gives out_rd=1.

Optional Feature:
- VX_MATRIX_UOP_PERF_EN defined:
  - adds output perf_uops (NUM_CH*32), per-channel micro-op handshake counters, saturating at 2^32-1 and cleared by reset;
  - adds output perf_clamp (32), counting accepted macros whose in_rows exceeded MAX_ROWS.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package holds:
  - the kind encoding localparams: UOP_NORMAL, UOP_MLOAD, UOP_MSTORE, UOP_MMUL;
  - a uop_kind_t typedef;
  - a packed uop_t struct {kind, rd, rs1, rs2, imm, idx, last, payload}.
- One sub-module, vx_matrix_uop_chan, implements a single channel's FSM, holding registers and expansion datapath. It is generated NUM_CH times.
- The top level does only in_ready muxing, accept steering, the optional perf logic, and output flattening.

Test Plan:
- Reset with in_valid=1 -> all out_valid=0, in_ready=1 for every in_ch, out data 0.
- MLOAD ch0, rows=4, rd=8, imm=0x100, out_ready=1 -> 4 cycles of out_rd 8,9,10,11; out_imm 0x100,0x104,0x108,0x10C; out_last on the 4th; in_ready for ch0 = 0 until the last handshake.
- MMUL ch1, rows=2, rd=10, rs1=20 -> uops (rd,rs1,rs2) = (10,20,22), (11,21,23).
- MSTORE ch2, rows=3, with out_ready[2] toggling 1,0,1,0,1 -> uops are held stable while stalled; a concurrent NORMAL on ch3 is accepted and emitted unaffected.
- MLOAD rows=12 with MAX_ROWS=8 -> exactly 8 uops emitted; perf_clamp increments when VX_MATRIX_UOP_PERF_EN is defined.
- Reset asserted at k=1 of a 4-row MMUL -> the next cycle out_valid=0; a fresh NORMAL afterwards emits exactly 1 uop with out_last=1.
